register_write_arbiter: RTL and testbench
=========================================

// Module: register_write_arbiter
// PURPOSE
//   Shares one enabled register (a/en/y interface, 1-cycle update latency) among NUM_REQ requesters.
//   Round-robin arbitration, valid/ready accept, sequenced write, one response pulse per completed write.
//   Sits between compiler-generated producer logic and a single shared `register` instance.
// PARAMETERS
//   NUM_REQ  4  number of requesters, 2..16
//   WIDTH    8  data width of the shared register
// PORTS
//   clock      in   1              clock; all logic on posedge
//   reset      in   1              synchronous, active-high
//   req_valid  in   NUM_REQ        per-requester write request
//   req_data   in   NUM_REQ*WIDTH  write data; requester i uses [i*WIDTH +: WIDTH]
//   req_ready  out  NUM_REQ        one-hot accept pulse, single cycle
//   reg_a      out  WIDTH          data to shared register input a
//   reg_en     out  1              enable to shared register
//   reg_y      in   WIDTH          shared register output y
//   rsp_valid  out  1              one-cycle pulse: write completed
//   rsp_id     out  $clog2(NUM_REQ) requester index of completed write
//   rsp_data   out  WIDTH          value written (reg_y sampled in the CHECK state when the macro is set)
//   err        out  1              sticky readback mismatch flag
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, req_ready=0, reg_a=0, reg_en=0, rsp_valid=0, rsp_id=0, rsp_data=0, err=0.
//   Reset wins over everything; reset mid-write aborts it with no rsp_valid. The shared register's own reset is separate.
//   FSM states: IDLE -> WRITE -> (CHECK) -> IDLE.
//   IDLE: if any req_valid, grant = first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
//     req_ready[grant]=1 this cycle (combinational from req_valid/rr_ptr); latch data and id; go WRITE.
//     No valid requester: stay IDLE, all outputs idle.
//   WRITE: reg_a=latched data, reg_en=1 for exactly one cycle; rr_ptr <= (grant+1) mod NUM_REQ.
//   Outside WRITE: reg_en=0 and reg_a holds its last value.
//   req_valid deasserting after accept does not cancel the write.
//   Non-granted requesters keep valid asserted; no ready is given outside IDLE.
//   Fairness: a continuously-valid requester is granted within NUM_REQ grants.
//   Simultaneous valid on all lines with rr_ptr=k: grant order k, k+1, ..., wrap.
//   rr_ptr wraps from NUM_REQ-1 to 0 (NUM_REQ need not be a power of two).
// CONFIGURATION
//   Macro REGISTER_WRITE_ARBITER_READBACK_EN:
//   defined:
//     WRITE -> CHECK. CHECK samples reg_y (updated one cycle after en).
//     rsp_valid=1, rsp_id=grant, rsp_data=reg_y.
//     If reg_y != latched data, err <= 1 (sticky until reset). CHECK -> IDLE.
//     Accept-to-accept spacing: 3 cycles.
//   undefined:
//     No CHECK state; rsp_valid pulses in the cycle after WRITE (state=IDLE) with rsp_data=latched data.
//     A new accept may occur in that same cycle. err tied 0. Accept-to-accept spacing: 2 cycles.
// STRUCTURE
//   Package register_arb_pkg:
//     state enum (IDLE, WRITE, CHECK), 2-bit encoding.
//     function idx_w(n) = max(1, $clog2(n)).
//   Sub-module rr_pick:
//     combinational round-robin picker.
//     Inputs: valid[NUM_REQ], ptr. Outputs: grant_oh, grant_idx, any.
//   Top holds the FSM, data/id latch, rr_ptr, response and err registers.
// TESTING
//   Drive a real `register` instance as DUT load; check both macro settings.
//   1 Post-reset idle: 16 cycles reset, no valid -> reg_en=0, req_ready=0, rsp_valid=0, err=0 throughout.
//   2 Single write: req_valid[2]=1 data 8'd9 -> req_ready=4'b0100 once; reg_en one cycle with reg_a=9;
//     rsp_valid with rsp_id=2, rsp_data=9; register y=9 afterwards.
//   3 All four valid continuously, data i+1 -> grant order 0,1,2,3,0; rsp_id sequence matches;
//     spacing 3 cycles (READBACK_EN) / 2 cycles (not).
//   4 Valid drop after accept: req_valid[1] pulsed one cycle with data 8'd5 -> write still completes, rsp_id=1, y=5.
//   5 Reset mid-write: reset asserted in the WRITE cycle -> no rsp_valid; rr_ptr=0, so the next grant with all valid is 0.
//   6 READBACK_EN mismatch: reg_y forced to 8'd3 while writing 8'd7 -> err=1 after CHECK; err stays 1 until reset.

Source files
------------

// File: rtl/register_write_arbiter_pkg.sv
// Shared types for the register write arbiter: FSM state encoding and index-width helper.
package register_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Index width that stays at least one bit even for a single requester.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import register_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);

  always_comb begin
    int j;
    j         = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && valid[j]) begin
        any         = 1'b1;
        grant_idx   = IW'(j);
        grant_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one enabled register among NUM_REQ requesters, one response per write.
// Define REGISTER_WRITE_ARBITER_READBACK_EN to add a CHECK state that verifies reg_y and sets sticky err.
module register_write_arbiter
  import register_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           reg_a,
  output logic                       reg_en,
  input  logic [WIDTH-1:0]           reg_y,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       err
);

  localparam int IW = idx_w(NUM_REQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]     grant_idx;
  logic              any;
`ifndef REGISTER_WRITE_ARBITER_READBACK_EN
  logic              rsp_valid_q, rsp_valid_d;
  logic              unused_reg_y;
  assign unused_reg_y = ^reg_y;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    data_d     = data_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    req_ready  = '0;
    reg_en     = 1'b0;
`ifndef REGISTER_WRITE_ARBITER_READBACK_EN
    rsp_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          // Accept is suppressed during reset so nothing is handed off that would be lost.
          req_ready = reset ? '0 : grant_oh;
          id_d      = grant_idx;
          data_d    = req_data[grant_idx*WIDTH +: WIDTH];
          state_d   = WRITE;
        end
      end
      WRITE: begin
        reg_en   = 1'b1;
        rr_ptr_d = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
`ifdef REGISTER_WRITE_ARBITER_READBACK_EN
        state_d  = CHECK;
`else
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = data_q;
`endif
      end
      CHECK: begin
`ifdef REGISTER_WRITE_ARBITER_READBACK_EN
        rsp_id_d   = id_q;
        rsp_data_d = reg_y;
        if (reg_y != data_q) err_d = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
`ifndef REGISTER_WRITE_ARBITER_READBACK_EN
      rsp_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      data_q     <= data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
`ifndef REGISTER_WRITE_ARBITER_READBACK_EN
      rsp_valid_q <= rsp_valid_d;
`endif
    end
  end

  // The latched data doubles as reg_a: it only changes on accept, so it holds between writes.
  assign reg_a = data_q;
  assign err   = err_q;

`ifdef REGISTER_WRITE_ARBITER_READBACK_EN
  assign rsp_valid = (state_q == CHECK);
  assign rsp_id    = rsp_valid ? id_q  : rsp_id_q;
  assign rsp_data  = rsp_valid ? reg_y : rsp_data_q;
`else
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
`endif

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter driving a behavioural shared register as load.
module tb_register_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef REGISTER_WRITE_ARBITER_READBACK_EN
  localparam int S = 3;
`else
  localparam int S = 2;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   reg_a;
  logic           reg_en;
  logic [W-1:0]   reg_y;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           err;

  logic [W-1:0]   y_q = '0;
  logic           force_y = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Shared register: y follows a one cycle after en; force_y corrupts the readback path.
  always @(posedge clock) if (reg_en) y_q <= reg_a;
  assign reg_y = force_y ? 8'd3 : y_q;

  register_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_a     (reg_a),
    .reg_en    (reg_en),
    .reg_y     (reg_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: post-reset idle
    for (int c = 0; c < 16; c++) begin
      @(negedge clock); #1;
      chk("rst_en", reg_en, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err", err, 0);
    end
    @(negedge clock); reset = 1'b0; #1;
    chk("idle_reg_a", reg_a, 0);
    chk("idle_rsp_id", rsp_id, 0);
    chk("idle_rsp_data", rsp_data, 0);
    chk("idle_en", reg_en, 0);

    // 2: single write from requester 2
    @(negedge clock); req_valid = 4'b0100; req_data[2*W +: W] = 8'd9; #1;
    chk("t2_ready", req_ready, 4'b0100);
    chk("t2_en_accept", reg_en, 0);
    @(negedge clock); req_valid = '0; #1;
    chk("t2_en", reg_en, 1);
    chk("t2_reg_a", reg_a, 9);
    chk("t2_ready_write", req_ready, 0);
    @(negedge clock); #1;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_id", rsp_id, 2);
    chk("t2_rsp_data", rsp_data, 9);
    chk("t2_en_off", reg_en, 0);
    @(negedge clock); #1;
    chk("t2_rsp_valid_off", rsp_valid, 0);
    chk("t2_y", reg_y, 9);

    // 4: requester 1 drops valid right after accept (rr_ptr is 3)
    @(negedge clock); req_valid = 4'b0010; req_data[1*W +: W] = 8'd5; #1;
    chk("t4_ready", req_ready, 4'b0010);
    @(negedge clock); req_valid = '0; #1;
    chk("t4_en", reg_en, 1);
    chk("t4_reg_a", reg_a, 5);
    @(negedge clock); #1;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_id", rsp_id, 1);
    chk("t4_rsp_data", rsp_data, 5);
    @(negedge clock); #1;
    chk("t4_y", reg_y, 5);

    // 5: reset during WRITE (rr_ptr is 2, so grant 2 first)
    @(negedge clock); req_valid = 4'b1111; req_data = {8'd4, 8'd3, 8'd2, 8'd1}; #1;
    chk("t5_ready", req_ready, 4'b0100);
    @(negedge clock); #1;
    chk("t5_en", reg_en, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_en_rst", reg_en, 0);
    chk("t5_ready_rst", req_ready, 0);
    reset = 1'b0;

    // 3: all four valid continuously from rr_ptr=0
    for (int t = 0; t <= 5*S + 1; t++) begin
      logic rv;
      if (t > 0) @(negedge clock);
      #1;
      rv = (t >= 2) && ((t - 2) % S == 0);
      chk("t3_ready", req_ready, (t % S == 0) ? (32'd1 << ((t / S) % 4)) : 32'd0);
      chk("t3_en", reg_en, (t % S == 1) ? 1 : 0);
      chk("t3_rsp_valid", rsp_valid, rv);
      if (rv) begin
        chk("t3_rsp_id", rsp_id, ((t - 2) / S) % 4);
        chk("t3_rsp_data", rsp_data, ((t - 2) / S) % 4 + 1);
      end
      if (t % S == 1) chk("t3_reg_a", reg_a, ((t - 1) / S) % 4 + 1);
    end
    req_valid = '0;
    repeat (3) @(negedge clock);

    // 6: corrupted readback
    force_y = 1'b1;
    @(negedge clock); req_valid = 4'b0001; req_data[0 +: W] = 8'd7; #1;
    chk("t6_ready", req_ready, 4'b0001);
    chk("t6_err_before", err, 0);
    @(negedge clock); req_valid = '0; #1;
    chk("t6_en", reg_en, 1);
    chk("t6_reg_a", reg_a, 7);
    @(negedge clock); #1;
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_rsp_id", rsp_id, 0);
    chk("t6_err_in_rsp", err, 0);
`ifdef REGISTER_WRITE_ARBITER_READBACK_EN
    chk("t6_rsp_data", rsp_data, 3);
`else
    chk("t6_rsp_data", rsp_data, 7);
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); #1;
`ifdef REGISTER_WRITE_ARBITER_READBACK_EN
      chk("t6_err_sticky", err, 1);
`else
      chk("t6_err_tied", err, 0);
`endif
    end
    reset = 1'b1;
    @(negedge clock); #1;
    chk("t6_err_cleared", err, 0);
    reset = 1'b0;
    force_y = 1'b0;
    @(negedge clock); #1;
    chk("t6_err_after", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
